// File: rtl/matmul_int_tile_ctrl.sv
// Tile sequencer for an integer matmul array.
// It walks every (A row-tile, B column-tile) pair in row-major order. For each
// tile it strobes a single operand/scale buffer read, waits out the array
// pipeline latency, and holds the result until the consumer accepts it.
//
//   state | meaning
//   IDLE  | waiting for i_start; tile indices held at 0
//   ISSUE | one-cycle buffer read strobe for the current tile
//   WAIT  | array pipeline in flight, ARRAY_LAT cycles on a down-counter
//   OUT   | result presented, held until i_out_ready
//   DONE  | one-cycle end-of-sweep pulse
module matmul_int_tile_ctrl #(
  parameter  int ROW_TILES = 4,
  parameter  int COL_TILES = 4,
  parameter  int ARRAY_LAT = 3,
  localparam int AW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1,
  localparam int BW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_rd_en,
  output logic [AW-1:0] o_a_tile,
  output logic [BW-1:0] o_b_tile,
  output logic          o_out_valid,
  output logic          o_done
);

  // ARRAY_LAT tops out at 255, so an 8-bit counter always suffices.
  localparam int            CW       = 8;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ARRAY_LAT - 1);
  localparam logic [AW-1:0] A_LAST   = AW'(ROW_TILES - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(COL_TILES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, rd_en_q, out_valid_q, done_q;

  // Next-state, tile index and latency counter logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        a_d   = '0;
        b_d   = '0;
        cnt_d = '0;
        // An abort arriving alongside a start cancels it.
        if (i_start && !i_abort) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_OUT: begin
        if (i_out_ready) begin
          if (a_q == A_LAST && b_q == B_LAST) begin
            state_d = S_DONE;
            a_d     = '0;
            b_d     = '0;
          end else if (b_q == B_LAST) begin
            state_d = S_ISSUE;
            b_d     = '0;
            a_d     = a_q + AW'(1);
          end else begin
            state_d = S_ISSUE;
            b_d     = b_q + BW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort overrides any transition, including a simultaneous acceptance.
    if (state_q != S_IDLE && i_abort) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
    end
  end

  // State, indices, counter, and outputs registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      busy_q      <= (state_d != S_IDLE);
      rd_en_q     <= (state_d == S_ISSUE);
      out_valid_q <= (state_d == S_OUT);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign o_busy      = busy_q;
  assign o_rd_en     = rd_en_q;
  assign o_out_valid = out_valid_q;
  assign o_done      = done_q;
  assign o_a_tile    = a_q;
  assign o_b_tile    = b_q;

endmodule

// File: tb/tb_matmul_int_tile_ctrl.sv
// Directed bench for matmul_int_tile_ctrl: a 2x2/LAT=3 instance and a 1x1/LAT=1 instance.
// Cycle c begins at rising edge c; inputs change 1 time unit after the edge,
// and outputs are sampled on the falling edge.
module tb_matmul_int_tile_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst_a, start_a, abort_a, ready_a;
  logic busy_a, rd_a, vld_a, done_a;
  logic a_a, b_a;

  logic rst_s, start_s, abort_s, ready_s;
  logic busy_s, rd_s, vld_s, done_s;
  logic a_s, b_s;

  matmul_int_tile_ctrl #(.ROW_TILES(2), .COL_TILES(2), .ARRAY_LAT(3)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .i_abort(abort_a),
    .i_out_ready(ready_a), .o_busy(busy_a), .o_rd_en(rd_a), .o_a_tile(a_a),
    .o_b_tile(b_a), .o_out_valid(vld_a), .o_done(done_a)
  );

  matmul_int_tile_ctrl #(.ROW_TILES(1), .COL_TILES(1), .ARRAY_LAT(1)) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_start(start_s), .i_abort(abort_s),
    .i_out_ready(ready_s), .o_busy(busy_s), .o_rd_en(rd_s), .o_a_tile(a_s),
    .o_b_tile(b_s), .o_out_valid(vld_s), .o_done(done_s)
  );

  task automatic test_reset();
    logic [3:0] exp_c;
    @(posedge clk); #1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      rst_a = (c <= 2); rst_s = (c <= 2);
      start_a = (c <= 3); abort_a = (c == 4); ready_a = 1'b1;
      start_s = 1'b0; abort_s = 1'b0; ready_s = 1'b1;
      @(negedge clk);
      exp_c = {(c == 4), (c == 4), 1'b0, 1'b0};
      checks++;
      if ({busy_a, rd_a, vld_a, done_a} !== exp_c) begin
        errors++;
        $display("FAIL reset_ctrl c=%0d got %b exp %b", c, {busy_a, rd_a, vld_a, done_a}, exp_c);
      end
      checks++;
      if ({a_a, b_a} !== 2'b00) begin
        errors++;
        $display("FAIL reset_tile c=%0d got %b exp 00", c, {a_a, b_a});
      end
      checks++;
      if ({busy_s, rd_s, vld_s, done_s, a_s, b_s} !== 6'b000000) begin
        errors++;
        $display("FAIL reset_single c=%0d got %b exp 000000", c, {busy_s, rd_s, vld_s, done_s, a_s, b_s});
      end
    end
  endtask

  task automatic test_basic_sweep(input bit restart_mid);
    logic [31:0] rd_m, vld_m;
    int win[4];
    logic ta[4], tb_t[4];
    logic [3:0] exp_c;
    int k;
    rd_m = '0; rd_m[1] = 1'b1; rd_m[6] = 1'b1; rd_m[11] = 1'b1; rd_m[16] = 1'b1;
    vld_m = '0; vld_m[5] = 1'b1; vld_m[10] = 1'b1; vld_m[15] = 1'b1; vld_m[20] = 1'b1;
    win = '{1, 6, 11, 16};
    ta = '{1'b0, 1'b0, 1'b1, 1'b1};
    tb_t = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(posedge clk); #1;
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      start_a = (c == 0) || (restart_mid && c == 8);
      abort_a = 1'b0; ready_a = 1'b1;
      @(negedge clk);
      exp_c = {(c >= 1 && c <= 21), rd_m[c], vld_m[c], (c == 21)};
      checks++;
      if ({busy_a, rd_a, vld_a, done_a} !== exp_c) begin
        errors++;
        $display("FAIL sweep_ctrl restart=%0d c=%0d got %b exp %b", restart_mid, c, {busy_a, rd_a, vld_a, done_a}, exp_c);
      end
      if (rd_m[c] || vld_m[c]) begin
        k = 0;
        for (int j = 0; j < 4; j++) if (win[j] <= c) k = j;
        checks++;
        if ({a_a, b_a} !== {ta[k], tb_t[k]}) begin
          errors++;
          $display("FAIL sweep_tile restart=%0d c=%0d got %b exp %b", restart_mid, c, {a_a, b_a}, {ta[k], tb_t[k]});
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] rd_m, vld_m;
    int win[4];
    logic ta[4], tb_t[4];
    logic [3:0] exp_c;
    int k;
    rd_m = '0; rd_m[1] = 1'b1; rd_m[9] = 1'b1; rd_m[14] = 1'b1; rd_m[19] = 1'b1;
    vld_m = '0; vld_m[5] = 1'b1; vld_m[6] = 1'b1; vld_m[7] = 1'b1; vld_m[8] = 1'b1;
    vld_m[13] = 1'b1; vld_m[18] = 1'b1; vld_m[23] = 1'b1;
    win = '{1, 9, 14, 19};
    ta = '{1'b0, 1'b0, 1'b1, 1'b1};
    tb_t = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(posedge clk); #1;
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      start_a = (c == 0); abort_a = 1'b0;
      ready_a = !(c >= 5 && c <= 7);
      @(negedge clk);
      exp_c = {(c >= 1 && c <= 24), rd_m[c], vld_m[c], (c == 24)};
      checks++;
      if ({busy_a, rd_a, vld_a, done_a} !== exp_c) begin
        errors++;
        $display("FAIL bp_ctrl c=%0d got %b exp %b", c, {busy_a, rd_a, vld_a, done_a}, exp_c);
      end
      if (rd_m[c] || vld_m[c]) begin
        k = 0;
        for (int j = 0; j < 4; j++) if (win[j] <= c) k = j;
        checks++;
        if ({a_a, b_a} !== {ta[k], tb_t[k]}) begin
          errors++;
          $display("FAIL bp_tile c=%0d got %b exp %b", c, {a_a, b_a}, {ta[k], tb_t[k]});
        end
      end
    end
    ready_a = 1'b1;
  endtask

  // Abort mid-WAIT, abort+start in IDLE, restart, then abort coinciding with acceptance.
  task automatic test_abort();
    logic [3:0] exp_c;
    @(posedge clk); #1;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      start_a = (c == 0) || (c == 4) || (c == 6);
      abort_a = (c == 3) || (c == 4) || (c == 11);
      ready_a = 1'b1;
      @(negedge clk);
      exp_c = {((c >= 1 && c <= 3) || (c >= 7 && c <= 11)), (c == 1 || c == 7), (c == 11), 1'b0};
      checks++;
      if ({busy_a, rd_a, vld_a, done_a} !== exp_c) begin
        errors++;
        $display("FAIL abort_ctrl c=%0d got %b exp %b", c, {busy_a, rd_a, vld_a, done_a}, exp_c);
      end
      if (c == 1 || c == 7 || c == 11 || c == 12) begin
        checks++;
        if ({a_a, b_a} !== 2'b00) begin
          errors++;
          $display("FAIL abort_tile c=%0d got %b exp 00", c, {a_a, b_a});
        end
      end
    end
    abort_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_c;
    logic [1:0] exp_t;
    @(posedge clk); #1;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      start_a = (c == 0) || (c == 12);
      rst_a = (c == 10) || (c == 14);
      abort_a = 1'b0; ready_a = 1'b1;
      @(negedge clk);
      exp_c = {((c >= 1 && c <= 10) || (c >= 13 && c <= 14)), (c == 1 || c == 6 || c == 13),
               (c == 5 || c == 10), 1'b0};
      checks++;
      if ({busy_a, rd_a, vld_a, done_a} !== exp_c) begin
        errors++;
        $display("FAIL rstmid_ctrl c=%0d got %b exp %b", c, {busy_a, rd_a, vld_a, done_a}, exp_c);
      end
      if (c == 1 || c == 5 || c == 6 || c == 10 || c == 11 || c == 13 || c == 15) begin
        exp_t = (c == 6 || c == 10) ? 2'b01 : 2'b00;
        checks++;
        if ({a_a, b_a} !== exp_t) begin
          errors++;
          $display("FAIL rstmid_tile c=%0d got %b exp %b", c, {a_a, b_a}, exp_t);
        end
      end
    end
    rst_a = 1'b0;
  endtask

  // Single-tile instance, two sweeps back to back.
  task automatic test_single_tile();
    logic [3:0] exp_c;
    @(posedge clk); #1;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      start_s = (c == 0) || (c == 5);
      abort_s = 1'b0; ready_s = 1'b1;
      @(negedge clk);
      exp_c = {((c >= 1 && c <= 4) || (c >= 6 && c <= 9)), (c == 1 || c == 6),
               (c == 3 || c == 8), (c == 4 || c == 9)};
      checks++;
      if ({busy_s, rd_s, vld_s, done_s} !== exp_c) begin
        errors++;
        $display("FAIL single_ctrl c=%0d got %b exp %b", c, {busy_s, rd_s, vld_s, done_s}, exp_c);
      end
      checks++;
      if ({a_s, b_s} !== 2'b00) begin
        errors++;
        $display("FAIL single_tile c=%0d got %b exp 00", c, {a_s, b_s});
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
    rst_s = 1'b1; start_s = 1'b0; abort_s = 1'b0; ready_s = 1'b1;
    test_reset();
    test_basic_sweep(1'b0);
    test_back_pressure();
    test_abort();
    test_basic_sweep(1'b1);
    test_reset_mid();
    test_single_tile();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
